// File: rtl/pc_unit.sv
// Program counter with redirect priority and an optional return-address stack.
// The RAS is built only when PC_UNIT_RAS_EN is defined.
module pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                STEP         = 4,
    parameter int                RAS_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            call_push,
    input  logic            ret_pop,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            misalign_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);

    localparam logic [XLEN-1:0] STEP_X   = XLEN'(STEP);
    localparam logic [XLEN-1:0] LOW_MASK = STEP_X - XLEN'(1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            misalign_q;
    logic            misalign_d;

    logic            advance;
    logic            redirect;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] pc_plus;

    logic            ras_pop;
    logic [XLEN-1:0] ras_top;

    assign advance   = fetch_ready & ~stall;
    assign redirect  = trap_take | br_taken;
    assign redir_tgt = trap_take ? trap_vector : br_target;
    assign pc_plus   = pc_q + STEP_X;

    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redirect) begin
            pc_d       = redir_tgt & ~LOW_MASK;
            misalign_d = |(redir_tgt & LOW_MASK);
        end else if (ras_pop) begin
            pc_d = ras_top;
        end else if (advance) begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus_o  = pc_plus;
    assign misalign_o = misalign_q;

`ifdef PC_UNIT_RAS_EN

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   top_q;
    logic [PW-1:0]   top_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_push;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign ras_push  = call_push & advance & ~redirect;
    assign ras_pop   = ret_pop & advance & ~ras_empty & ~redirect;
    assign ras_top   = ras_q[top_q];

    // top_q always indexes the newest entry; a push into a full
    // stack lands on the oldest slot, giving circular overwrite.
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = top_q;
        if (trap_take) begin
            cnt_d = '0;
        end else if (ras_push && ras_pop) begin
            wr_en = 1'b1;
        end else if (ras_push) begin
            top_d  = top_q + PW'(1);
            wr_idx = top_q + PW'(1);
            wr_en  = 1'b1;
            if (!ras_full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (ras_pop) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            ras_q[wr_idx] <= pc_plus;
        end
    end

    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;

`else

    logic unused_ras_inputs;

    assign unused_ras_inputs = call_push ^ ret_pop;
    assign ras_pop           = 1'b0;
    assign ras_top           = '0;
    assign ras_empty_o       = 1'b1;
    assign ras_full_o        = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pc_unit;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 8;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic        stall;
    logic        trap_take;
    logic [31:0] trap_vector;
    logic        br_taken;
    logic [31:0] br_target;
    logic        call_push;
    logic        ret_pop;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;
    logic        misalign_o;
    logic        ras_empty_o;
    logic        ras_full_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] pc_m;
    logic        mis_m;
    logic [31:0] ras_m [$];

    pc_unit #(
        .XLEN(32),
        .RESET_VECTOR(RV),
        .STEP(4),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_ready(fetch_ready),
        .stall(stall),
        .trap_take(trap_take),
        .trap_vector(trap_vector),
        .br_taken(br_taken),
        .br_target(br_target),
        .call_push(call_push),
        .ret_pop(ret_pop),
        .pc_o(pc_o),
        .pc_plus_o(pc_plus_o),
        .misalign_o(misalign_o),
        .ras_empty_o(ras_empty_o),
        .ras_full_o(ras_full_o)
    );

    always #5 clk = ~clk;

    // Reference behaviour for one clock edge, from the priority rules.
    task automatic model_step();
        logic [31:0] nxt;
        logic [31:0] ret;
        if (reset) begin
            pc_m  = RV;
            mis_m = 1'b0;
            ras_m.delete();
        end else if (trap_take) begin
            pc_m  = {trap_vector[31:2], 2'b00};
            mis_m = (trap_vector[1:0] != 2'b00);
            ras_m.delete();
        end else if (br_taken) begin
            pc_m  = {br_target[31:2], 2'b00};
            mis_m = (br_target[1:0] != 2'b00);
        end else begin
            mis_m = 1'b0;
            if (fetch_ready && !stall) begin
                ret = pc_m + 32'd4;
                nxt = ret;
                if (RAS_EN && ret_pop && ras_m.size() > 0) begin
                    nxt = ras_m[ras_m.size()-1];
                    void'(ras_m.pop_back());
                end
                if (RAS_EN && call_push) begin
                    ras_m.push_back(ret);
                    if (ras_m.size() > DEPTH) void'(ras_m.pop_front());
                end
                pc_m = nxt;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle();
        reset       = 1'b0;
        fetch_ready = 1'b0;
        stall       = 1'b0;
        trap_take   = 1'b0;
        trap_vector = '0;
        br_taken    = 1'b0;
        br_target   = '0;
        call_push   = 1'b0;
        ret_pop     = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset       = 1'b1;
        fetch_ready = 1'b1;
        br_taken    = 1'b1;
        br_target   = 32'h3333;
        tick();
        tick();
        tests++; if (pc_o !== 32'h100) begin fails++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h100); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL reset_mis got %b want 0", misalign_o); end
        tests++; if (ras_empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", ras_empty_o); end
        tests++; if (ras_full_o !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", ras_full_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        idle();
        fetch_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            want = 32'h100 + 32'(4 * i);
            tests++; if (pc_o !== want) begin fails++; $display("FAIL seq_pc%0d got %h want %h", i, pc_o, want); end
        end
        tests++; if (pc_plus_o !== 32'h110) begin fails++; $display("FAIL seq_plus got %h want %h", pc_plus_o, 32'h110); end
        fetch_ready = 1'b0;
        tick();
        tests++; if (pc_o !== 32'h10C) begin fails++; $display("FAIL seq_hold got %h want %h", pc_o, 32'h10C); end
    endtask

    task automatic test_branch_stall();
        idle();
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h2002;
        tick();
        tests++; if (pc_o !== 32'h2000) begin fails++; $display("FAIL br_pc got %h want %h", pc_o, 32'h2000); end
        tests++; if (misalign_o !== 1'b1) begin fails++; $display("FAIL br_mis got %b want 1", misalign_o); end
        br_taken = 1'b0;
        tick();
        tests++; if (pc_o !== 32'h2000) begin fails++; $display("FAIL br_hold got %h want %h", pc_o, 32'h2000); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL br_mis_clr got %b want 0", misalign_o); end
    endtask

    task automatic test_trap();
        idle();
        fetch_ready = 1'b1;
        call_push   = 1'b1;
        tick();
        idle();
        trap_take   = 1'b1;
        trap_vector = 32'h80;
        br_taken    = 1'b1;
        br_target   = 32'h500;
        tick();
        tests++; if (pc_o !== 32'h80) begin fails++; $display("FAIL trap_pc got %h want %h", pc_o, 32'h80); end
        tests++; if (ras_empty_o !== 1'b1) begin fails++; $display("FAIL trap_empty got %b want 1", ras_empty_o); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL trap_mis got %b want 0", misalign_o); end
    endtask

`ifdef PC_UNIT_RAS_EN
    task automatic test_ras();
        logic [31:0] want;
        idle();
        br_taken  = 1'b1;
        br_target = 32'h40;
        tick();
        idle();
        fetch_ready = 1'b1;
        call_push   = 1'b1;
        tick();
        tests++; if (ras_empty_o !== 1'b0) begin fails++; $display("FAIL ras_call_empty got %b want 0", ras_empty_o); end
        idle();
        br_taken  = 1'b1;
        br_target = 32'h200;
        tick();
        idle();
        fetch_ready = 1'b1;
        repeat (3) tick();
        ret_pop = 1'b1;
        tick();
        tests++; if (pc_o !== 32'h44) begin fails++; $display("FAIL ras_ret got %h want %h", pc_o, 32'h44); end
        tests++; if (ras_empty_o !== 1'b1) begin fails++; $display("FAIL ras_ret_empty got %b want 1", ras_empty_o); end
        ret_pop   = 1'b0;
        call_push = 1'b1;
        repeat (9) tick();
        tests++; if (ras_full_o !== 1'b1) begin fails++; $display("FAIL ras_full got %b want 1", ras_full_o); end
        tests++; if (pc_o !== 32'h68) begin fails++; $display("FAIL ras_push_pc got %h want %h", pc_o, 32'h68); end
        call_push = 1'b0;
        ret_pop   = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            want = 32'h68 - 32'(4 * j);
            tests++; if (pc_o !== want) begin fails++; $display("FAIL ras_pop%0d got %h want %h", j, pc_o, want); end
        end
        tests++; if (ras_empty_o !== 1'b1) begin fails++; $display("FAIL ras_drain got %b want 1", ras_empty_o); end
        tick();
        tests++; if (pc_o !== 32'h50) begin fails++; $display("FAIL ras_pop_empty got %h want %h", pc_o, 32'h50); end
    endtask
`endif

    task automatic test_wrap();
        idle();
        trap_take   = 1'b1;
        trap_vector = 32'hFFFF_FFFC;
        tick();
        tests++; if (pc_plus_o !== 32'h0) begin fails++; $display("FAIL wrap_plus got %h want 0", pc_plus_o); end
        idle();
        fetch_ready = 1'b1;
        ret_pop     = 1'b1;
        tick();
        tests++; if (pc_o !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h want 0", pc_o); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL wrap_mis got %b want 0", misalign_o); end
        tick();
        tests++; if (pc_o !== 32'h4) begin fails++; $display("FAIL wrap_ret_empty got %h want 4", pc_o); end
    endtask

    task automatic test_reset_mid();
        idle();
        fetch_ready = 1'b1;
        call_push   = 1'b1;
        repeat (3) tick();
        idle();
        reset     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h7770;
        tick();
        tests++; if (pc_o !== RV) begin fails++; $display("FAIL rst_mid_pc got %h want %h", pc_o, RV); end
        tests++; if (ras_empty_o !== 1'b1) begin fails++; $display("FAIL rst_mid_empty got %b want 1", ras_empty_o); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL rst_mid_mis got %b want 0", misalign_o); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic want_empty;
        logic want_full;
        for (int n = 0; n < 2000; n++) begin
            reset       = ($urandom_range(127) == 0);
            fetch_ready = ($urandom_range(3) != 0);
            stall       = ($urandom_range(7) == 0);
            trap_take   = ($urandom_range(31) == 0);
            br_taken    = ($urandom_range(7) == 0);
            trap_vector = $urandom;
            br_target   = $urandom;
            call_push   = ($urandom_range(3) == 0);
            ret_pop     = ($urandom_range(3) == 0);
            tick();
            want_empty = RAS_EN ? (ras_m.size() == 0) : 1'b1;
            want_full  = RAS_EN ? (ras_m.size() == DEPTH) : 1'b0;
            tests++; if (pc_o !== pc_m) begin fails++; $display("FAIL rnd_pc n=%0d got %h want %h", n, pc_o, pc_m); end
            tests++; if (pc_plus_o !== pc_m + 32'd4) begin fails++; $display("FAIL rnd_plus n=%0d got %h want %h", n, pc_plus_o, pc_m + 32'd4); end
            tests++; if (misalign_o !== mis_m) begin fails++; $display("FAIL rnd_mis n=%0d got %b want %b", n, misalign_o, mis_m); end
            tests++; if (ras_empty_o !== want_empty) begin fails++; $display("FAIL rnd_empty n=%0d got %b want %b", n, ras_empty_o, want_empty); end
            tests++; if (ras_full_o !== want_full) begin fails++; $display("FAIL rnd_full n=%0d got %b want %b", n, ras_full_o, want_full); end
        end
        idle();
    endtask

    initial begin
        pc_m  = RV;
        mis_m = 1'b0;
        test_reset();
        test_sequential();
        test_branch_stall();
        test_trap();
`ifdef PC_UNIT_RAS_EN
        test_ras();
`endif
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
